wfrm_pkt_parser: RTL and testbench

WFRM_PKT_PARSER -- requirements
Module: wfrm_pkt_parser

---
 rtl/wfrm_pkt_parser_pkg.sv | 25 ++
 rtl/wfrm_pkt_parser_if.sv | 12 +
 rtl/wfrm_pkt_parser.sv | 172 +++++++++++++++++
 tb/tb_wfrm_pkt_parser.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wfrm_pkt_parser_pkg.sv
// Shared constants for the waveform-load packet parser: command word,
// header layout and the parser state encoding.
package wfrm_pkt_parser_pkg;

  localparam int          DATA_W        = 32;
  localparam logic [31:0] WFRM_CMD_WORD = 32'h5757_4441;

  localparam int OFS_CMD   = 0;
  localparam int OFS_ID    = 1;
  localparam int OFS_IND   = 2;
  localparam int OFS_LEN   = 3;
  localparam int OFS_RSV   = 4;
  localparam int HDR_WORDS = 5;

  typedef enum logic [2:0] {
    H_CMD   = 3'd0,
    H_ID    = 3'd1,
    H_IND   = 3'd2,
    H_LEN   = 3'd3,
    H_RSV   = 3'd4,
    PAYLOAD = 3'd5,
    DROP    = 3'd6
  } state_t;

endpackage

// File: rtl/wfrm_pkt_parser_if.sv
// AXI-Stream style word channel feeding the waveform-load parser.
interface wfrm_pkt_parser_if;
  import wfrm_pkt_parser_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/wfrm_pkt_parser.sv
// Parses multi-packet waveform loads into sequential RAM writes, tracking
// segment order and reporting completion and protocol errors.
module wfrm_pkt_parser
  import wfrm_pkt_parser_pkg::*;
#(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] CMD_WORD = WFRM_CMD_WORD
) (
  input  logic               clk_i,
  input  logic               resetn,
  wfrm_pkt_parser_if.slave   s_axis,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               done,
  output logic [31:0]        done_id,
  output logic [31:0]        done_len,
  output logic               err_cmd,
  output logic               err_seq,
  output logic               err_short,
  output logic               err_len,
  output logic               err_ovf,
  output logic               busy
);

  localparam logic [ADDR_W:0] PTR_LAST = {1'b0, {ADDR_W{1'b1}}};

  state_t          state, state_nxt;
  logic            acc;
  logic [31:0]     hdr_id, hdr_ind, hdr_len;
  logic [31:0]     cur_id, cur_len, exp_ind, cnt;
  logic [ADDR_W:0] ptr;
  logic            len_flag;
  logic            open_load, wr_go, fin, ovf, pkt_ok;
  logic            e_cmd, e_seq, e_short, e_len;

  assign s_axis.tready = resetn;
  assign acc           = s_axis.tvalid & s_axis.tready;

  always_ff @(posedge clk_i) begin
    if (!resetn) state <= H_CMD;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    open_load = 1'b0;
    wr_go     = 1'b0;
    fin       = 1'b0;
    ovf       = 1'b0;
    pkt_ok    = 1'b0;
    e_cmd     = 1'b0;
    e_seq     = 1'b0;
    e_short   = 1'b0;
    e_len     = 1'b0;
    if (acc) begin
      unique case (state)
        H_CMD: begin
          if (s_axis.tdata != CMD_WORD) begin
            e_cmd     = 1'b1;
            state_nxt = s_axis.tlast ? H_CMD : DROP;
          end else if (s_axis.tlast) begin
            e_short = 1'b1;
          end else begin
            state_nxt = H_ID;
          end
        end
        H_ID, H_IND, H_LEN: begin
          e_short   = s_axis.tlast;
          state_nxt = s_axis.tlast ? H_CMD : state_t'(state + 3'd1);
        end
        H_RSV: begin
          if (s_axis.tlast) begin
            e_short   = 1'b1;
            state_nxt = H_CMD;
          end else if (hdr_ind == 32'd0) begin
            if (hdr_len == 32'd0) begin
              e_len     = 1'b1;
              state_nxt = DROP;
            end else begin
              open_load = 1'b1;
              state_nxt = PAYLOAD;
            end
          end else if (busy && hdr_id == cur_id && hdr_ind == exp_ind) begin
            state_nxt = PAYLOAD;
          end else begin
            e_seq     = 1'b1;
            state_nxt = DROP;
          end
        end
        PAYLOAD: begin
          if (busy) begin
            wr_go = 1'b1;
            if (cnt + 32'd1 == cur_len) fin = 1'b1;
            else if (ptr == PTR_LAST)   ovf = 1'b1;
          end else if (!len_flag) begin
            e_len = 1'b1;
          end
          if (ovf) begin
            state_nxt = s_axis.tlast ? H_CMD : DROP;
          end else if (s_axis.tlast) begin
            pkt_ok    = 1'b1;
            state_nxt = H_CMD;
          end
        end
        DROP: if (s_axis.tlast) state_nxt = H_CMD;
        default: state_nxt = H_CMD;
      endcase
    end
  end

  // Registered write/status stage: everything below appears one cycle after acceptance.
  always_ff @(posedge clk_i) begin
    if (!resetn) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
      done_id   <= '0;
      done_len  <= '0;
      err_cmd   <= 1'b0;
      err_seq   <= 1'b0;
      err_short <= 1'b0;
      err_len   <= 1'b0;
      err_ovf   <= 1'b0;
      busy      <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
      cur_id    <= '0;
      cur_len   <= '0;
      exp_ind   <= '0;
      hdr_id    <= '0;
      hdr_ind   <= '0;
      hdr_len   <= '0;
      len_flag  <= 1'b0;
    end else begin
      wr_en     <= wr_go;
      done      <= fin;
      err_cmd   <= e_cmd;
      err_seq   <= e_seq;
      err_short <= e_short;
      err_len   <= e_len;
      err_ovf   <= ovf;
      if (acc && state == H_ID)  hdr_id  <= s_axis.tdata;
      if (acc && state == H_IND) hdr_ind <= s_axis.tdata;
      if (acc && state == H_LEN) hdr_len <= s_axis.tdata;
      if (acc && state == H_RSV)            len_flag <= 1'b0;
      else if (e_len && state == PAYLOAD)   len_flag <= 1'b1;
      if (wr_go) begin
        wr_addr <= ptr[ADDR_W-1:0];
        wr_data <= s_axis.tdata;
        ptr     <= ptr + 1'b1;
        cnt     <= cnt + 32'd1;
      end
      if (fin) begin
        done_id  <= cur_id;
        done_len <= cur_len;
      end
      if (fin || ovf) busy <= 1'b0;
      // A new index-0 header silently replaces whatever load was open.
      if (open_load) begin
        cur_id  <= hdr_id;
        cur_len <= hdr_len;
        ptr     <= '0;
        cnt     <= '0;
        busy    <= 1'b1;
      end
      if (pkt_ok) exp_ind <= hdr_ind + 32'd1;
    end
  end

endmodule

// File: tb/tb_wfrm_pkt_parser.sv
// Directed plus randomized bench for wfrm_pkt_parser with a packet-level reference model.
module tb_wfrm_pkt_parser;
  import wfrm_pkt_parser_pkg::*;

  typedef struct packed { logic s; logic [31:0] a; logic [31:0] d; } wr_t;
  typedef struct packed { logic s; logic [31:0] id; logic [31:0] len; logic [31:0] a; } done_t;

  logic clk_i = 1'b0;
  logic resetn = 1'b0;
  always #5 clk_i = ~clk_i;

  wfrm_pkt_parser_if if0 ();
  wfrm_pkt_parser_if if1 ();

  logic        wr_en0, done0, ec0, es0, esh0, el0, eo0, busy0;
  logic [11:0] wr_addr0;
  logic [31:0] wr_data0, done_id0, done_len0;
  logic        wr_en1, done1, ec1, es1, esh1, el1, eo1, busy1;
  logic [7:0]  wr_addr1;
  logic [31:0] wr_data1, done_id1, done_len1;

  wfrm_pkt_parser #(.ADDR_W(12)) dut0 (
    .clk_i(clk_i), .resetn(resetn), .s_axis(if0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .done(done0), .done_id(done_id0), .done_len(done_len0),
    .err_cmd(ec0), .err_seq(es0), .err_short(esh0), .err_len(el0), .err_ovf(eo0),
    .busy(busy0));

  wfrm_pkt_parser #(.ADDR_W(8)) dut1 (
    .clk_i(clk_i), .resetn(resetn), .s_axis(if1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .done(done1), .done_id(done_id1), .done_len(done_len1),
    .err_cmd(ec1), .err_seq(es1), .err_short(esh1), .err_len(el1), .err_ovf(eo1),
    .busy(busy1));

  int checks = 0;
  int failures = 0;

  wr_t   act_wr[$], exp_wr[$];
  done_t act_done[$], exp_done[$];
  int act_cmd = 0, act_seq = 0, act_short = 0, act_len = 0, act_ovf = 0;
  int exp_cmd = 0, exp_seq = 0, exp_short = 0, exp_len = 0, exp_ovf = 0;

  // Model state per DUT
  int unsigned m_busy[2], m_id[2], m_len[2], m_cnt[2], m_exp[2];
  logic [31:0] pkt[$];

  always @(negedge clk_i) begin
    if (wr_en0) act_wr.push_back(wr_t'({1'b0, 32'(wr_addr0), wr_data0}));
    if (wr_en1) act_wr.push_back(wr_t'({1'b1, 32'(wr_addr1), wr_data1}));
    if (done0) act_done.push_back(done_t'({1'b0, done_id0, done_len0, wr_en0 ? 32'(wr_addr0) : 32'hFFFF_FFFF}));
    if (done1) act_done.push_back(done_t'({1'b1, done_id1, done_len1, wr_en1 ? 32'(wr_addr1) : 32'hFFFF_FFFF}));
    act_cmd   <= act_cmd   + int'(ec0)  + int'(ec1);
    act_seq   <= act_seq   + int'(es0)  + int'(es1);
    act_short <= act_short + int'(esh0) + int'(esh1);
    act_len   <= act_len   + int'(el0)  + int'(el1);
    act_ovf   <= act_ovf   + int'(eo0)  + int'(eo1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_busy[s] = 0; m_id[s] = 0; m_len[s] = 0; m_cnt[s] = 0; m_exp[s] = 0;
    end
  endtask

  // Whole-packet outcome computed from the packet rules
  task automatic model_pkt(input int sel);
    int unsigned cap = (sel != 0) ? 256 : 4096;
    int n = pkt.size();
    bit exc = 0, ov = 0;
    logic [31:0] id, ind, len;
    if (pkt[OFS_CMD] != WFRM_CMD_WORD) begin exp_cmd++; return; end
    if (n <= HDR_WORDS) begin exp_short++; return; end
    id = pkt[OFS_ID]; ind = pkt[OFS_IND]; len = pkt[OFS_LEN];
    if (ind == 0) begin
      if (len == 0) begin exp_len++; return; end
      m_busy[sel] = 1; m_id[sel] = id; m_len[sel] = len; m_cnt[sel] = 0;
    end else if (!(m_busy[sel] == 1 && id == m_id[sel] && ind == m_exp[sel])) begin
      exp_seq++; return;
    end
    for (int i = HDR_WORDS; i < n && !ov; i++) begin
      if (m_busy[sel] == 0) exc = 1;
      else begin
        exp_wr.push_back(wr_t'({sel[0], m_cnt[sel], pkt[i]}));
        m_cnt[sel]++;
        if (m_cnt[sel] == m_len[sel]) begin
          m_busy[sel] = 0;
          exp_done.push_back(done_t'({sel[0], m_id[sel], m_len[sel], m_cnt[sel] - 32'd1}));
        end else if (m_cnt[sel] == cap) begin
          m_busy[sel] = 0; ov = 1; exp_ovf++;
        end
      end
    end
    if (exc) exp_len++;
    if (!ov) m_exp[sel] = ind + 1;
  endtask

  task automatic mk_pkt(input logic [31:0] id, input logic [31:0] ind, input logic [31:0] len, input int npay);
    pkt.delete();
    pkt.push_back(WFRM_CMD_WORD); pkt.push_back(id); pkt.push_back(ind);
    pkt.push_back(len); pkt.push_back($urandom);
    for (int i = 0; i < npay; i++) pkt.push_back($urandom);
  endtask

  task automatic set_if(input int sel, input logic [31:0] d, input logic l, input logic v);
    if (sel == 0) begin if0.tdata = d; if0.tlast = l; if0.tvalid = v; end
    else          begin if1.tdata = d; if1.tlast = l; if1.tvalid = v; end
  endtask

  task automatic send(input int sel);
    for (int i = 0; i < pkt.size(); i++) begin
      while ($urandom_range(0, 3) == 0) begin
        set_if(sel, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        @(posedge clk_i); #1;
      end
      set_if(sel, pkt[i], i == pkt.size() - 1, 1'b1);
      @(posedge clk_i); #1;
    end
    set_if(sel, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic run_pkt(input int sel);
    model_pkt(sel);
    send(sel);
  endtask

  task automatic check_all(input string tag);
    repeat (3) @(posedge clk_i);
    #1;
    chk({tag, ".nwr"}, 128'(act_wr.size()), 128'(exp_wr.size()));
    while (act_wr.size() > 0 && exp_wr.size() > 0)
      chk({tag, ".wr"}, 128'(act_wr.pop_front()), 128'(exp_wr.pop_front()));
    act_wr.delete(); exp_wr.delete();
    chk({tag, ".ndone"}, 128'(act_done.size()), 128'(exp_done.size()));
    while (act_done.size() > 0 && exp_done.size() > 0)
      chk({tag, ".done"}, 128'(act_done.pop_front()), 128'(exp_done.pop_front()));
    act_done.delete(); exp_done.delete();
    chk({tag, ".err_cmd"},   128'(act_cmd),   128'(exp_cmd));
    chk({tag, ".err_seq"},   128'(act_seq),   128'(exp_seq));
    chk({tag, ".err_short"}, 128'(act_short), 128'(exp_short));
    chk({tag, ".err_len"},   128'(act_len),   128'(exp_len));
    chk({tag, ".err_ovf"},   128'(act_ovf),   128'(exp_ovf));
    chk({tag, ".busy0"},     128'(busy0),     128'(m_busy[0]));
    chk({tag, ".busy1"},     128'(busy1),     128'(m_busy[1]));
  endtask

  initial begin
    logic [31:0] bad;
    int r;
    set_if(0, 32'd0, 1'b0, 1'b0);
    set_if(1, 32'd0, 1'b0, 1'b0);
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst.tready", 128'(if0.tready), 128'(0));
    chk("rst.wr_en",  128'(wr_en0), 128'(0));
    chk("rst.busy",   128'(busy0), 128'(0));
    chk("rst.done",   128'(done0), 128'(0));
    chk("rst.errs",   128'({ec0, es0, esh0, el0, eo0}), 128'(0));
    chk("rst.data",   128'({wr_addr0, wr_data0, done_id0, done_len0}), 128'(0));
    resetn = 1'b1;
    @(posedge clk_i); #1;
    chk("tready", 128'(if0.tready), 128'(1));

    // Four 256-word segments of one 1004-sample waveform
    for (int k = 0; k < 4; k++) begin
      mk_pkt(32'd0, k, 32'd1004, 251);
      run_pkt(0);
    end
    check_all("load4");

    mk_pkt(32'd1, 32'd0, 32'd20, 3);
    pkt[0] = 32'h1234_5678;
    run_pkt(0);
    check_all("badcmd");
    mk_pkt(32'd5, 32'd0, 32'd20, 20);
    run_pkt(0);
    check_all("afterbad");

    mk_pkt(32'd7, 32'd0, 32'd500, 50);
    run_pkt(0);
    mk_pkt(32'd7, 32'd2, 32'd500, 30);
    run_pkt(0);
    check_all("skipind");
    chk("skipind.busy", 128'(busy0), 128'(1));
    mk_pkt(32'd7, 32'd1, 32'd500, 30);
    run_pkt(0);
    check_all("resume");

    mk_pkt(32'd8, 32'd0, 32'd10, 0);
    while (pkt.size() > 4) void'(pkt.pop_back());
    run_pkt(0);
    chk("short.state", 128'(dut0.state), 128'(H_CMD));
    check_all("short");

    mk_pkt(32'd9, 32'd0, 32'd10, 251);
    run_pkt(0);
    check_all("excess");

    mk_pkt(32'd10, 32'd0, 32'd0, 5);
    run_pkt(0);
    check_all("len0");

    // Reset in the middle of a continuation packet
    mk_pkt(32'd11, 32'd0, 32'd100, 20);
    run_pkt(0);
    check_all("preRst");
    mk_pkt(32'd11, 32'd1, 32'd100, 20);
    for (int i = 0; i < 3; i++) begin
      set_if(0, pkt[i], 1'b0, 1'b1);
      @(posedge clk_i); #1;
    end
    resetn = 1'b0;
    set_if(0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("midrst.busy", 128'(busy0), 128'(0));
    resetn = 1'b1;
    model_reset();
    run_pkt(0);
    check_all("postRst");

    for (int it = 0; it < 12; it++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: begin
          do bad = $urandom; while (bad == WFRM_CMD_WORD);
          mk_pkt($urandom, 0, 5, $urandom_range(0, 6));
          pkt[0] = bad;
        end
        1: begin
          mk_pkt($urandom, 0, 5, 0);
          while (pkt.size() > $urandom_range(2, 5)) void'(pkt.pop_back());
        end
        2: mk_pkt($urandom_range(0, 3), 0, $urandom_range(1, 60), $urandom_range(1, 40));
        3: mk_pkt(m_id[0], m_exp[0] + 1, 5, $urandom_range(1, 20));
        default: mk_pkt(m_id[0], m_exp[0], 5, $urandom_range(1, 40));
      endcase
      run_pkt(0);
      check_all("rand");
    end

    // Narrow RAM: the load outgrows 256 samples
    mk_pkt(32'd3, 32'd0, 32'd300, 200);
    run_pkt(1);
    check_all("ovfA");
    mk_pkt(32'd3, 32'd1, 32'd300, 100);
    run_pkt(1);
    check_all("ovfB");
    chk("ovf.busy", 128'(busy1), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
